// File: rtl/binaryman_divseq_pkg.sv
// Shared widths, FSM encodings and uio pin indices for the sequential divider tile.
package binaryman_divseq_pkg;

    localparam int DW = 8;   // dividend / quotient width
    localparam int VW = 4;   // divisor / remainder width
    localparam int CW = 3;   // iteration counter width, clog2(DW)

    localparam int START_BIT = 4;
    localparam int RSEL_BIT  = 5;
    localparam int BUSY_BIT  = 6;
    localparam int DONE_BIT  = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/divseq_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and report the quotient bit.
module divseq_step
    import binaryman_divseq_pkg::*;
(
    input  logic [VW:0]   i_p,
    input  logic          i_bit,
    input  logic [VW-1:0] i_d,
    output logic [VW:0]   o_p_next,
    output logic          o_qbit
);

    logic [VW:0] w_shift;
    logic [VW:0] w_div;

    assign w_shift = {i_p[VW-1:0], i_bit};
    assign w_div   = {1'b0, i_d};

    // The extra partial-remainder bit keeps the compare and subtract free of overflow.
    always_comb begin
        o_qbit   = (w_shift >= w_div);
        o_p_next = o_qbit ? (w_shift - w_div) : w_shift;
    end

endmodule

// File: rtl/tt_um_binaryman_divseq.sv
// TinyTapeout tile: 8-bit / 4-bit sequential restoring divider, one quotient bit per clock.
// Optional macro DIVSEQ_DZ_DETECT_EN: divisor 0 finishes after one step with Q=8'hFF, R=4'hF.
module tt_um_binaryman_divseq
    import binaryman_divseq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    output logic [7:0] uo_out
);

    state_t        r_state, w_state_next;
    logic [DW-1:0] r_n,     w_n_next;
    logic [VW-1:0] r_d,     w_d_next;
    logic [DW-1:0] r_qw,    w_qw_next;
    logic [VW:0]   r_p,     w_p_next;
    logic [CW-1:0] r_cnt,   w_cnt_next;
    logic [DW-1:0] r_q,     w_q_next;
    logic [VW-1:0] r_r,     w_r_next;

    logic          w_start;
    logic          w_rsel;
    logic          w_dz;
    logic [VW:0]   w_step_p;
    logic          w_qbit;
    logic [DW-1:0] w_qw_shift;
    logic          w_unused;

    assign w_start    = uio_in[START_BIT];
    assign w_rsel     = uio_in[RSEL_BIT];
    assign w_unused   = &{1'b0, uio_in[7:6]};
    assign w_qw_shift = {r_qw[DW-2:0], w_qbit};

`ifdef DIVSEQ_DZ_DETECT_EN
    assign w_dz = (r_d == '0);
`else
    assign w_dz = 1'b0;
`endif

    divseq_step u_step (
        .i_p      (r_p),
        .i_bit    (r_n[DW-1]),
        .i_d      (r_d),
        .o_p_next (w_step_p),
        .o_qbit   (w_qbit)
    );

    always_comb begin
        w_state_next = r_state;
        w_n_next     = r_n;
        w_d_next     = r_d;
        w_qw_next    = r_qw;
        w_p_next     = r_p;
        w_cnt_next   = r_cnt;
        w_q_next     = r_q;
        w_r_next     = r_r;

        case (r_state)
            IDLE, DONE: begin
                if (w_start) begin
                    w_n_next     = ui_in;
                    w_d_next     = uio_in[VW-1:0];
                    w_qw_next    = '0;
                    w_p_next     = '0;
                    w_cnt_next   = '0;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_dz) begin
                    w_q_next     = '1;
                    w_r_next     = '1;
                    w_state_next = DONE;
                end else begin
                    w_p_next   = w_step_p;
                    w_n_next   = {r_n[DW-2:0], 1'b0};
                    w_qw_next  = w_qw_shift;
                    w_cnt_next = r_cnt + 1'b1;
                    // Visible result changes only here, so the previous answer holds through RUN.
                    if (r_cnt == CW'(DW - 1)) begin
                        w_q_next     = w_qw_shift;
                        w_r_next     = w_step_p[VW-1:0];
                        w_state_next = DONE;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_n     <= '0;
            r_d     <= '0;
            r_qw    <= '0;
            r_p     <= '0;
            r_cnt   <= '0;
            r_q     <= '0;
            r_r     <= '0;
        end else if (ena) begin
            r_state <= w_state_next;
            r_n     <= w_n_next;
            r_d     <= w_d_next;
            r_qw    <= w_qw_next;
            r_p     <= w_p_next;
            r_cnt   <= w_cnt_next;
            r_q     <= w_q_next;
            r_r     <= w_r_next;
        end
    end

    always_comb begin
        uio_out           = '0;
        uio_out[BUSY_BIT] = (r_state == RUN);
        uio_out[DONE_BIT] = (r_state == DONE);
    end

    assign uio_oe = 8'hC0;
    assign uo_out = w_rsel ? {{(DW-VW){1'b0}}, r_r} : r_q;

endmodule

// File: tb/tb_tt_um_binaryman_divseq.sv
// Scoreboard bench for the sequential divider tile: stimulus pushes expected results,
// a monitor pops and compares each time done rises.
module tb_tt_um_binaryman_divseq;

`ifdef DIVSEQ_DZ_DETECT_EN
    localparam bit DZ = 1'b1;
`else
    localparam bit DZ = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [3:0] tb_d;
    logic       tb_start;
    logic       tb_rsel;
    logic [1:0] tb_hi;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic [7:0] uo_out;

    assign uio_in = {tb_hi, tb_rsel, tb_start, tb_d};

    tt_um_binaryman_divseq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .uo_out  (uo_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] n;
        logic [3:0] d;
        logic [7:0] q;
        logic [3:0] r;
    } res_t;

    res_t       sb[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] last_q  = 8'h00;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: plain integer division; divisor 0 gives all-ones quotient.
    function automatic res_t model(input logic [7:0] n, input logic [3:0] d);
        res_t e;
        e.n = n;
        e.d = d;
        if (d == 4'd0) begin
            e.q = 8'hFF;
            e.r = DZ ? 4'hF : n[3:0];
        end else begin
            e.q = 8'(n / d);
            e.r = 4'(n % d);
        end
        return e;
    endfunction

    // Monitor: owns rsel, reads quotient and remainder just after each done rise.
    initial begin : monitor
        logic       prev_done;
        logic       dn;
        logic [7:0] q_pin;
        logic [7:0] r_pin;
        res_t       e;
        prev_done = 1'b0;
        tb_rsel   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            dn = uio_out[7];
            if (dn && !prev_done) begin
                q_pin   = uo_out;
                tb_rsel = 1'b1;
                #1;
                r_pin   = uo_out;
                tb_rsel = 1'b0;
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: got q=%0d r=%0d expected no result", q_pin, r_pin);
                end else begin
                    e = sb.pop_front();
                    check("quotient", q_pin, e.q);
                    check("remainder_pin", r_pin, {4'b0, e.r});
                    if (e.d != 4'd0) begin
                        check("q*d+r==n", int'(q_pin) * int'(e.d) + int'(r_pin[3:0]), int'(e.n));
                        check("r<d", r_pin[3:0] < e.d, 1);
                    end
                end
            end
            prev_done = dn;
        end
    end

    // mode 0 plain, 1 ena drop mid-RUN, 2 start re-pulse mid-RUN, 3 reset mid-RUN.
    // cyc counts negedges after the accepting edge: done after edge t+8 is cyc 9.
    task automatic run_op(input logic [7:0] n, input logic [3:0] d, input int mode);
        res_t e;
        int   cyc;
        int   exp_cyc;
        e = model(n, d);
        @(negedge clk);
        ui_in    = n;
        tb_d     = d;
        tb_start = 1'b1;
        tb_hi    = 2'($urandom);
        sb.push_back(e);
        @(negedge clk);
        tb_start = 1'b0;
        ui_in    = 8'($urandom);
        tb_d     = 4'($urandom);
        cyc      = 1;
        exp_cyc  = (DZ && d == 4'd0) ? 2 : 9;
        if (mode == 1) exp_cyc += 5;
        while (!uio_out[7] && cyc < 40) begin
            check("busy_in_run", uio_out[6], 1);
            check("q_hold_in_run", uo_out, last_q);
            if (mode == 1) ena = (cyc >= 3 && cyc < 8) ? 1'b0 : 1'b1;
            if (mode == 2) tb_start = (cyc == 3);
            if (mode == 3 && cyc == 4) begin
                rst_n = 1'b0;
                #1;
                check("rst_busy", uio_out[6], 0);
                check("rst_done", uio_out[7], 0);
                check("rst_uo_out", uo_out, 0);
                sb.delete();
                last_q = 8'h00;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            @(negedge clk);
            cyc++;
        end
        ena      = 1'b1;
        tb_start = 1'b0;
        check("latency", cyc, exp_cyc);
        check("busy_low_at_done", uio_out[6], 0);
        last_q = e.q;
    endtask

    task automatic sweep();
        int cyc;
        for (int n = 0; n < 256; n++) begin
            for (int d = 1; d < 16; d++) begin
                ui_in    = 8'(n);
                tb_d     = 4'(d);
                tb_start = 1'b1;
                sb.push_back(model(8'(n), 4'(d)));
                @(negedge clk);
                cyc = 1;
                while (!uio_out[7] && cyc < 20) begin
                    @(negedge clk);
                    cyc++;
                end
                check("sweep_latency", cyc, 9);
                last_q = model(8'(n), 4'(d)).q;
            end
        end
        tb_start = 1'b0;
    endtask

    initial begin : stim
        int waited;
        rst_n    = 1'b0;
        ena      = 1'b1;
        ui_in    = 8'h00;
        tb_d     = 4'h0;
        tb_start = 1'b0;
        tb_hi    = 2'b00;
        #12;
        check("reset_uo_out", uo_out, 0);
        check("reset_uio_out", uio_out, 0);
        check("uio_oe", uio_oe, 8'hC0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(8'd143, 4'd11, 0);
        run_op(8'd200, 4'd7, 0);
        run_op(8'd255, 4'd1, 0);
        run_op(8'd10, 4'd0, 0);
        run_op(8'd100, 4'd3, 2);
        run_op(8'd77, 4'd5, 1);
        run_op(8'd200, 4'd9, 3);
        check("post_reset_uo_out", uo_out, 0);
        run_op(8'd143, 4'd11, 0);

        repeat (150) run_op(8'($urandom), 4'($urandom), 0);

        sweep();

        waited = 0;
        while (sb.size() != 0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("scoreboard_drained", sb.size(), 0);
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
